// File: rtl/sample_window3_pkg.sv
// Shared constants and helpers for the sample_window3 input conditioner.
package sample_window3_pkg;

    localparam int WIN_W    = 3;
    localparam int DEF_DIV  = 8;
    localparam int DEF_HOLD = 2;
    localparam int DEF_CW   = 8;

    function automatic logic maj3(input logic [WIN_W-1:0] w);
        return (w[2] & w[1]) | (w[1] & w[0]) | (w[0] & w[2]);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Prescaler producing a one-cycle sample tick every DIV enabled clocks.
module sample_tick_gen #(
    parameter int DIV = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic sample_tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count;

    assign sample_tick = en && (count == CNT_W'(DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (sample_tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sample_window3.sv
// Synchronises din, keeps a 3-sample window for the voter and derives
// a hysteretic filtered level with edge pulses and a glitch counter.
module sample_window3
    import sample_window3_pkg::*;
#(
    parameter int DIV  = DEF_DIV,
    parameter int HOLD = DEF_HOLD,
    parameter int CW   = DEF_CW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          din,
    input  logic          en,
    input  logic          glitch_clr,
    output logic          a,
    output logic          b,
    output logic          c,
    output logic          sample_tick,
    output logic          filt,
    output logic          rise,
    output logic          fall,
    output logic [CW-1:0] glitch_cnt
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic             sync_q1;
    logic             din_s;
    logic [WIN_W-1:0] win;
    logic             tick_d;
    logic [HW-1:0]    hold_cnt;
    logic             maj;
    logic             mixed;

    sample_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .sample_tick(sample_tick)
    );

    assign maj   = maj3(win);
    assign mixed = (win != '0) && (win != '1);

    assign a = win[2];
    assign b = win[1];
    assign c = win[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            din_s   <= 1'b0;
            win     <= '0;
            tick_d  <= 1'b0;
        end else begin
            sync_q1 <= din;
            din_s   <= sync_q1;
            tick_d  <= sample_tick;
            if (sample_tick) begin
                win <= {win[WIN_W-2:0], din_s};
            end
        end
    end

    // Evaluation runs the cycle after the shift so it sees the new window.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            filt     <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick_d) begin
                if (maj == filt) begin
                    hold_cnt <= '0;
                end else if (hold_cnt == HW'(HOLD - 1)) begin
                    filt     <= maj;
                    hold_cnt <= '0;
                    rise     <= maj;
                    fall     <= !maj;
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (tick_d && mixed && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + CW'(1);
        end
    end

endmodule
